// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    localparam logic REQ_CPU    = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    localparam int RD_LAT_DEFAULT = 1;

endpackage

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin pick: on a tie, the requester that did not win last time is chosen.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else begin
            winner = req1 ? REQ_LOADER : REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU data port and a loader/DMA master onto one memory bus,
// one transaction at a time: IDLE -> ACCESS -> (WAIT) -> DONE -> IDLE.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_we,
    input  logic        m0_re,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_we,
    input  logic        m1_re,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT >= 2 ? RD_LAT - 2 : 0);

    state_t      state;
    logic        last_gnt;
    logic        owner;
    logic        lat_we;
    logic        lat_re;
    logic [1:0]  wait_cnt;
    logic        pick;
    logic        pick_valid;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_we;
    logic        sel_re;
    logic        is_read;
    logic        capture;
    logic        complete;

    arb_rr2 u_arb (
        .req0     (m0_req),
        .req1     (m1_req),
        .last_gnt (last_gnt),
        .winner   (pick),
        .valid    (pick_valid)
    );

    assign sel_addr  = (pick == REQ_LOADER) ? m1_addr  : m0_addr;
    assign sel_wdata = (pick == REQ_LOADER) ? m1_wdata : m0_wdata;
    assign sel_we    = (pick == REQ_LOADER) ? m1_we    : m0_we;
    assign sel_re    = (pick == REQ_LOADER) ? m1_re    : m0_re;

    // A request with both qualifiers set is a write; only a pure read waits for data.
    assign is_read  = lat_re & ~lat_we;
    assign capture  = (state == ACCESS && is_read && RD_LAT == 1) ||
                      (state == WAIT && wait_cnt == 2'd0);
    assign complete = (state == ACCESS && !is_read) || capture;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values and the branches cannot race each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_gnt  <= REQ_LOADER;
            owner     <= REQ_CPU;
            lat_we    <= 1'b0;
            lat_re    <= 1'b0;
            wait_cnt  <= 2'd0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_done   <= 1'b0;
            m1_done   <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick;
                        last_gnt  <= pick;
                        lat_we    <= sel_we;
                        lat_re    <= sel_re;
                        // bus_addr/bus_wdata double as the request latch and hold until the next grant.
                        bus_addr  <= sel_addr;
                        bus_wdata <= sel_wdata;
                        bus_we    <= sel_we;
                        bus_re    <= sel_re & ~sel_we;
                        m0_gnt    <= (pick == REQ_CPU);
                        m1_gnt    <= (pick == REQ_LOADER);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    bus_we <= 1'b0;
                    bus_re <= 1'b0;
                    if (is_read && RD_LAT > 1) begin
                        wait_cnt <= WAIT_INIT;
                        state    <= WAIT;
                    end else begin
                        state <= DONE;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                DONE: begin
                    m0_gnt   <= 1'b0;
                    m1_gnt   <= 1'b0;
                    m0_done  <= 1'b0;
                    m1_done  <= 1'b0;
                    m0_rdata <= '0;
                    m1_rdata <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (complete) begin
                m0_done <= (owner == REQ_CPU);
                m1_done <= (owner == REQ_LOADER);
            end
            if (capture) begin
                if (owner == REQ_CPU) begin
                    m0_rdata <= bus_rdata;
                end else begin
                    m1_rdata <= bus_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard of expected bus strobes and done pulses,
// plus a second instance with a three-cycle read latency.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct {
        logic        id;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } bus_exp_t;

    typedef struct {
        logic        id;
        logic [31:0] rdata;
        int          cyc;
    } done_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m0_re, m1_req, m1_we, m1_re;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;
    logic        m0_gnt, m0_done, m1_gnt, m1_done, bus_we, bus_re;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;

    logic        s_req, s_re;
    logic [31:0] s_addr, s_bus_rdata;
    logic        s_gnt, s_done, s1_gnt, s1_done, s_bus_we, s_bus_re;
    logic [31:0] s_rdata, s1_rdata, s_bus_addr, s_bus_wdata;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rem0 = 0;
    int rem1 = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we), .m0_re(m0_re),
        .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_done(m0_done),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we), .m1_re(m1_re),
        .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_done(m1_done),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rdata(bus_rdata)
    );

    mem_arbiter #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(s_req), .m0_addr(s_addr), .m0_wdata(32'h0), .m0_we(1'b0), .m0_re(s_re),
        .m0_gnt(s_gnt), .m0_rdata(s_rdata), .m0_done(s_done),
        .m1_req(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0), .m1_we(1'b0), .m1_re(1'b0),
        .m1_gnt(s1_gnt), .m1_rdata(s1_rdata), .m1_done(s1_done),
        .bus_addr(s_bus_addr), .bus_wdata(s_bus_wdata), .bus_we(s_bus_we), .bus_re(s_bus_re),
        .bus_rdata(s_bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares every strobe and done pulse against the head of its queue;
    // a requester drops req once its last expected done has been seen.
    task automatic monitor();
        bus_exp_t  b;
        done_exp_t d;
        if (bus_we || bus_re) begin
            check("bus_expected", 32'(bus_q.size() != 0), 32'd1);
            if (bus_q.size() != 0) begin
                b = bus_q.pop_front();
                check("bus_we", 32'(bus_we), 32'(b.we));
                check("bus_re", 32'(bus_re), 32'(b.re));
                check("bus_addr", bus_addr, b.addr);
                check("bus_wdata", bus_wdata, b.wdata);
                check("strobe_gnt", 32'(b.id ? m1_gnt : m0_gnt), 32'd1);
                if (b.cyc >= 0) check("strobe_cycle", 32'(cyc), 32'(b.cyc));
            end
        end
        if (m0_done || m1_done) begin
            check("done_expected", 32'(done_q.size() != 0), 32'd1);
            check("done_one_hot", 32'(m0_done & m1_done), 32'd0);
            if (done_q.size() != 0) begin
                d = done_q.pop_front();
                check("done_id", 32'(m1_done), 32'(d.id));
                check("done_rdata", d.id ? m1_rdata : m0_rdata, d.rdata);
                check("done_gnt", {30'd0, m1_gnt, m0_gnt}, d.id ? 32'd2 : 32'd1);
                if (d.cyc >= 0) check("done_cycle", 32'(cyc), 32'(d.cyc));
            end
            if (m0_done) begin
                rem0--;
                if (rem0 <= 0) m0_req = 1'b0;
            end
            if (m1_done) begin
                rem1--;
                if (rem1 <= 0) m1_req = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
    endtask

    task automatic drive(input logic id, input logic we, input logic re,
                         input logic [31:0] addr, input logic [31:0] wdata, input int count);
        if (id == REQ_LOADER) begin
            m1_req = 1'b1; m1_we = we; m1_re = re; m1_addr = addr; m1_wdata = wdata; rem1 = count;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_re = re; m0_addr = addr; m0_wdata = wdata; rem0 = count;
        end
    endtask

    task automatic expect_txn(input logic id, input logic we, input logic re,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rd, input int bus_off, input int done_off);
        bus_exp_t  b;
        done_exp_t d;
        if (we || re) begin
            b.id = id; b.we = we; b.re = re & ~we; b.addr = addr; b.wdata = wdata;
            b.cyc = cyc + bus_off;
            bus_q.push_back(b);
        end
        if (done_off >= 0) begin
            d.id = id;
            d.rdata = (re && !we) ? rd : 32'h0;
            d.cyc = cyc + done_off;
            done_q.push_back(d);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((bus_q.size() != 0 || done_q.size() != 0 || m0_req || m1_req) && n < budget) begin
            step();
            n++;
        end
        check("drain_pending", 32'(bus_q.size() + done_q.size()), 32'd0);
        bus_q.delete();
        done_q.delete();
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes, dones, done_at;
        logic [31:0] rd_at;
        rst_n = 1'b0;
        {m0_req, m0_we, m0_re, m1_req, m1_we, m1_re} = '0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata} = '0;
        {s_req, s_re, s_addr, s_bus_rdata} = '0;

        #12;
        check("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("rst_done", {30'd0, m1_done, m0_done}, 32'd0);
        check("rst_strobe", {30'd0, bus_we, bus_re}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // Tie straight after reset: CPU first, loader next.
        bus_rdata = 32'h1111_2222;
        expect_txn(REQ_CPU, 1'b1, 1'b0, 32'h0000_0020, 32'h11, 32'h0, 1, 2);
        expect_txn(REQ_LOADER, 1'b0, 1'b1, 32'h0000_0030, 32'h0, bus_rdata, 4, 5);
        drive(REQ_CPU, 1'b1, 1'b0, 32'h0000_0020, 32'h11, 1);
        drive(REQ_LOADER, 1'b0, 1'b1, 32'h0000_0030, 32'h0, 1);
        drain(20);

        // Lone CPU write; address must hold on the bus afterwards.
        expect_txn(REQ_CPU, 1'b1, 1'b0, 32'h1000_0004, 32'hA5, 32'h0, 1, 2);
        drive(REQ_CPU, 1'b1, 1'b0, 32'h1000_0004, 32'hA5, 1);
        drain(20);
        check("bus_addr_hold", bus_addr, 32'h1000_0004);
        check("bus_wdata_hold", bus_wdata, 32'hA5);

        // Tie after a CPU win: the loader goes first this time.
        bus_rdata = 32'hCAFE_0001;
        expect_txn(REQ_LOADER, 1'b1, 1'b0, 32'h0000_0200, 32'h5, 32'h0, 1, 2);
        expect_txn(REQ_CPU, 1'b0, 1'b1, 32'h0000_0300, 32'h0, bus_rdata, 4, 5);
        drive(REQ_CPU, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 1);
        drive(REQ_LOADER, 1'b1, 1'b0, 32'h0000_0200, 32'h5, 1);
        drain(20);

        // Loader read with single-cycle latency.
        bus_rdata = 32'hDEAD_BEEF;
        expect_txn(REQ_LOADER, 1'b0, 1'b1, 32'h0000_0010, 32'h0, bus_rdata, 1, 2);
        drive(REQ_LOADER, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 1);
        drain(20);

        // Both hold req for three transactions each: strict alternation from the CPU.
        for (int n = 0; n < 6; n++) begin
            if (n % 2 == 0)
                expect_txn(REQ_CPU, 1'b1, 1'b0, 32'h0000_1000, 32'hAAAA_0000, 32'h0, 1 + 3 * n, 2 + 3 * n);
            else
                expect_txn(REQ_LOADER, 1'b1, 1'b0, 32'h0000_2000, 32'hBBBB_0000, 32'h0, 1 + 3 * n, 2 + 3 * n);
        end
        drive(REQ_CPU, 1'b1, 1'b0, 32'h0000_1000, 32'hAAAA_0000, 3);
        drive(REQ_LOADER, 1'b1, 1'b0, 32'h0000_2000, 32'hBBBB_0000, 3);
        drain(40);

        // Nop completes without a strobe; we+re behaves as a write.
        bus_rdata = 32'h5555_AAAA;
        expect_txn(REQ_CPU, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 0, 2);
        drive(REQ_CPU, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 1);
        drain(20);
        expect_txn(REQ_LOADER, 1'b1, 1'b1, 32'h0000_0044, 32'h77, 32'h0, 1, 2);
        drive(REQ_LOADER, 1'b1, 1'b1, 32'h0000_0044, 32'h77, 1);
        drain(20);

        // Request withdrawn and address changed after grant: transaction still completes.
        bus_rdata = 32'h0BAD_F00D;
        expect_txn(REQ_CPU, 1'b0, 1'b1, 32'h0000_0050, 32'h0, bus_rdata, 1, 2);
        drive(REQ_CPU, 1'b0, 1'b1, 32'h0000_0050, 32'h0, 1);
        step();
        m0_req = 1'b0; m0_addr = 32'hFFFF_FFF0; m0_we = 1'b1;
        drain(20);
        check("bus_addr_after_change", bus_addr, 32'h0000_0050);

        // Reset during ACCESS: strobe and grant drop at once, no done follows.
        expect_txn(REQ_CPU, 1'b1, 1'b0, 32'h0000_0060, 32'h9, 32'h0, 1, -1);
        drive(REQ_CPU, 1'b1, 1'b0, 32'h0000_0060, 32'h9, 1);
        step();
        #2 rst_n = 1'b0;
        #1;
        check("abort_strobe", {30'd0, bus_we, bus_re}, 32'd0);
        check("abort_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        check("abort_bus_addr", bus_addr, 32'd0);
        m0_req = 1'b0;
        step();
        step();
        @(negedge clk) rst_n = 1'b1;
        step();
        expect_txn(REQ_CPU, 1'b1, 1'b0, 32'h0000_0070, 32'h1, 32'h0, 1, 2);
        expect_txn(REQ_LOADER, 1'b1, 1'b0, 32'h0000_0080, 32'h2, 32'h0, 4, 5);
        drive(REQ_CPU, 1'b1, 1'b0, 32'h0000_0070, 32'h1, 1);
        drive(REQ_LOADER, 1'b1, 1'b0, 32'h0000_0080, 32'h2, 1);
        drain(20);

        // Three-cycle read latency with req dropped while waiting.
        s_bus_rdata = 32'h3C3C_5A5A;
        s_req = 1'b1; s_re = 1'b1; s_addr = 32'h0000_0090;
        strobes = 0; dones = 0; done_at = -1; rd_at = '0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (s_bus_re || s_bus_we) strobes++;
            if (s_done) begin
                dones++;
                done_at = i;
                rd_at = s_rdata;
            end
            if (i == 2) s_req = 1'b0;
        end
        check("lat3_strobes", 32'(strobes), 32'd1);
        check("lat3_dones", 32'(dones), 32'd1);
        check("lat3_done_cycle", 32'(done_at), 32'd4);
        check("lat3_rdata", rd_at, 32'h3C3C_5A5A);
        check("lat3_idle_gnt", 32'(s_gnt | s1_gnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1, meaning cycles from bus_re strobe to valid bus_rdata (legal range 1..4).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; the only reset.
REQ-004 m0_req  input  1  requester 0 (CPU data port) access request, held until m0_done.
REQ-005 m0_addr  input  32  requester 0 byte address.
REQ-006 m0_wdata  input  32  requester 0 write data.
REQ-007 m0_we / m0_re  input  1 each  requester 0 write / read qualifiers.
REQ-008 m0_gnt  output  1  requester 0 owns the bus.
REQ-009 m0_rdata  output  32  requester 0 read data, valid while m0_done high.
REQ-010 m0_done  output  1  one-cycle completion pulse to requester 0.
REQ-011 m1_req, m1_addr, m1_wdata, m1_we, m1_re, m1_gnt, m1_rdata, m1_done: identical set for requester 1 (UART loader / DMA master).
REQ-012 bus_addr  output  32  address to the address decoder.
REQ-013 bus_wdata  output  32  write data to RAM/MMIO.
REQ-014 bus_we / bus_re  output  1 each  mem_write / mem_read strobes to the address decoder.
REQ-015 bus_rdata  input  32  read-back data from the RAM/MMIO read mux.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, WAIT, DONE.
REQ-017 IDLE: no req -> stay; one req -> grant it; both -> grant requester not in last_gnt; last_gnt updates at grant.
REQ-018 At grant edge the block SHALL latch addr, wdata, we, re of the winner and enter ACCESS.
REQ-019 ACCESS lasts exactly 1 cycle: bus_addr/bus_wdata from latch, bus_we or bus_re high for that single cycle only.
REQ-020 Write (or we and re both high -> treated as write): ACCESS -> DONE.
REQ-021 Read: ACCESS -> WAIT for RD_LAT-1 cycles (0 when RD_LAT=1 -> direct to DONE path with capture), bus_rdata captured into winner rdata register on the RD_LAT-th edge after the ACCESS edge.
REQ-022 req with we=re=0: no bus strobe, ACCESS -> DONE (nop completes).
REQ-023 DONE lasts 1 cycle: winner mX_done=1, mX_rdata valid (reads; 0 for writes/nops); next state IDLE unconditionally.
REQ-024 mX_gnt high from ACCESS through DONE inclusive; never both gnt high.
REQ-025 Latency: req seen in IDLE -> done in cycle 2 (write/nop) or cycle 1+RD_LAT+... i.e. 2+RD_LAT-1 (read).
REQ-026 Deassertion of mX_req or change of mX_addr mid-transaction SHALL be ignored; transaction completes and done still pulses.
REQ-027 Loser's done/gnt stay 0; its req remains pending and wins the next IDLE cycle.
REQ-028 Outside ACCESS bus_we=bus_re=0; bus_addr/bus_wdata hold last latched values.
REQ-029 A requester holding req continuously SHALL alternate with the other; no starvation.

Reset
REQ-030 rst_n low asynchronously: state=IDLE, last_gnt=1 (so m0 wins first tie), all latches, gnt, done, rdata, bus outputs = 0.
REQ-031 Reset mid-transaction aborts it: no done pulse; bus strobes drop immediately.
REQ-032 Leaving reset, first IDLE evaluation occurs on the first rising edge with rst_n high.

Structure
REQ-033 Shared package holds state enum (IDLE, ACCESS, WAIT, DONE), requester ID constants (REQ_CPU=0, REQ_LOADER=1), RD_LAT default.
REQ-034 One sub-module arb_rr2: combinational 2-way round-robin pick from (req0, req1, last_gnt) -> winner, valid.
REQ-035 No other sub-modules; read-latency counter and latches live in mem_arbiter.

Verification
REQ-036 m0 write addr 0x10000004 data 0xA5 alone -> bus_we one cycle with bus_addr 0x10000004, m0_done cycle 2, m1 untouched.
REQ-037 m1 read 0x00000010, bus_rdata=0xDEADBEEF, RD_LAT=1 -> single bus_re, m1_rdata=0xDEADBEEF with m1_done.
REQ-038 m0 and m1 request same cycle after reset -> m0 first, m1 next, then repeated ties alternate m1/m0.
REQ-039 m0_req dropped during WAIT (RD_LAT=3) -> transaction completes, m0_done pulses once, no extra strobe.
REQ-040 rst_n low during ACCESS -> bus_we/bus_re and gnt drop same cycle, no done, next request handled normally.
REQ-041 Nop request (we=re=0) and we=re=1 -> no strobe / write-only strobe respectively, done pulse in both.
